// File: rtl/chip8_sprite_fetch.sv
// -----------------------------------------------------------------------------
// chip8_sprite_fetch
//
// DXYN sequencer that sits in front of the CHIP-8 display stage. A start
// request latches the X/Y origin, the sprite height n and the base address I.
// The block then fetches rows I..I+n-1 from memory, one at a time. Each row is
// presented to the display with a one-cycle draw strobe. The display's
// per-row collision flags are ORed together, and the result is reported as
// the VF value together with a done pulse.
//
// Row timing: READ(1) + WAIT(MEM_LAT) + DRAW(1) + CHECK(1) cycles per row.
// done is high n*(MEM_LAT+3)+1 cycles after the start-accept edge.
//
// Optional feature (compile-time macro CHIP8_SPRITE_CLIP_EN):
//   Rows with y+row_index >= 32 are skipped at no cycle cost. Pixels in
//   columns with x+col >= 64 are masked to 0.
//   Without the macro, every row is fetched and drawn unmodified, and
//   wrap-around is handled downstream.
//
// Parameters
//   ADDR_W   memory address width (address arithmetic wraps mod 2^ADDR_W)
//   MEM_LAT  memory read latency in cycles, 1..4
//
// Ports
//   clk          in   system clock, all state on posedge
//   reset        in   asynchronous active-low reset
//   start        in   one-cycle DXYN request, dropped while busy
//   vx, vy       in   coordinate sources (latched mod 64 / mod 32)
//   n            in   sprite height in rows
//   i_reg        in   sprite base address
//   mem_rd_en    out  memory read strobe
//   mem_addr     out  read address, valid with mem_rd_en
//   mem_rdata    in   read data, MEM_LAT cycles after mem_rd_en
//   draw         out  one-cycle row strobe to the display
//   x, y         out  latched origin
//   row_index    out  current row
//   sprite_data  out  row byte, MSB = leftmost pixel
//   collision    in   display collision flag, valid the cycle after draw
//   busy         out  high from start-accept until done
//   done         out  one-cycle completion pulse
//   vf_we        out  VF write strobe, coincident with done
//   vf_data      out  8'h01 if any row collided, else 8'h00
// -----------------------------------------------------------------------------
module chip8_sprite_fetch #(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        vx,
    input  logic [7:0]        vy,
    input  logic [3:0]        n,
    input  logic [ADDR_W-1:0] i_reg,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              draw,
    output logic [5:0]        x,
    output logic [4:0]        y,
    output logic [3:0]        row_index,
    output logic [7:0]        sprite_data,
    input  logic              collision,
    output logic              busy,
    output logic              done,
    output logic              vf_we,
    output logic [7:0]        vf_data
);

    localparam logic [2:0] LAT_C = 3'(MEM_LAT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DRAW   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

`ifdef CHIP8_SPRITE_CLIP_EN
    // Keep-mask for the row byte: bit b is pixel column 7-b.
    // A column survives only while it stays on the 64-pixel-wide screen.
    function automatic logic [7:0] col_mask(input logic [5:0] xo);
        logic [7:0] m;
        m = 8'h00;
        for (int b = 0; b < 8; b++) begin
            m[b] = (({1'b0, xo} + 7'(7 - b)) < 7'd64);
        end
        return m;
    endfunction
`endif

    state_t            state_r, state_s;
    logic [2:0]        wait_cnt_r, wait_cnt_s;
    logic [3:0]        n_r, n_s;
    logic [ADDR_W-1:0] base_r, base_s;
    logic              acc_r, acc_s;
    logic              last_row_s;

    logic              mem_rd_en_r, mem_rd_en_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic              draw_r, draw_s;
    logic [5:0]        x_r, x_s;
    logic [4:0]        y_r, y_s;
    logic [3:0]        row_r, row_s;
    logic [7:0]        data_r, data_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              vf_we_r, vf_we_s;
    logic [7:0]        vf_data_r, vf_data_s;

    // Next-state and next-output logic. All outputs are registered from these.
    always_comb begin
        state_s     = state_r;
        wait_cnt_s  = wait_cnt_r;
        n_s         = n_r;
        base_s      = base_r;
        acc_s       = acc_r;
        x_s         = x_r;
        y_s         = y_r;
        row_s       = row_r;
        data_s      = data_r;
        mem_rd_en_s = 1'b0;
        mem_addr_s  = mem_addr_r;
        draw_s      = 1'b0;
        busy_s      = busy_r;
        done_s      = 1'b0;
        vf_we_s     = 1'b0;
        vf_data_s   = 8'h00;

        // The last row is n-1. Under clipping, rows below the bottom edge are
        // dropped entirely. This ends the sprite early at zero cycle cost.
        // Once y+row reaches 32, every later row is off-screen too.
        last_row_s = (row_r == (n_r - 4'd1));
`ifdef CHIP8_SPRITE_CLIP_EN
        if (({1'b0, y_r} + {2'b00, row_r} + 6'd1) >= 6'd32) begin
            last_row_s = 1'b1;
        end else begin
            last_row_s = (row_r == (n_r - 4'd1));
        end
`endif

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    x_s    = vx[5:0];
                    y_s    = vy[4:0];
                    n_s    = n;
                    base_s = i_reg;
                    acc_s  = 1'b0;
                    row_s  = 4'd0;
                    busy_s = 1'b1;
                    if (n == 4'd0) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s     = ST_READ;
                        mem_rd_en_s = 1'b1;
                        mem_addr_s  = i_reg;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s    = ST_WAIT;
                wait_cnt_s = 3'd1;
            end
            ST_WAIT: begin
                if (wait_cnt_r == LAT_C) begin
`ifdef CHIP8_SPRITE_CLIP_EN
                    data_s = mem_rdata & col_mask(x_r);
`else
                    data_s = mem_rdata;
`endif
                    state_s = ST_DRAW;
                    draw_s  = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + 3'd1;
                end
            end
            ST_DRAW: begin
                state_s = ST_CHECK;
            end
            ST_CHECK: begin
                acc_s = acc_r | collision;
                if (last_row_s) begin
                    state_s = ST_FINISH;
                end else begin
                    row_s       = row_r + 4'd1;
                    state_s     = ST_READ;
                    mem_rd_en_s = 1'b1;
                    mem_addr_s  = base_r + ADDR_W'(row_r + 4'd1);
                end
            end
            ST_FINISH: begin
                state_s   = ST_IDLE;
                busy_s    = 1'b0;
                done_s    = 1'b1;
                vf_we_s   = 1'b1;
                vf_data_s = {7'b0000000, acc_r};
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, latched operands and registered outputs.
    // The asynchronous reset aborts any sequence in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 3'd0;
            n_r         <= 4'd0;
            base_r      <= '0;
            acc_r       <= 1'b0;
            mem_rd_en_r <= 1'b0;
            mem_addr_r  <= '0;
            draw_r      <= 1'b0;
            x_r         <= 6'd0;
            y_r         <= 5'd0;
            row_r       <= 4'd0;
            data_r      <= 8'h00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            vf_we_r     <= 1'b0;
            vf_data_r   <= 8'h00;
        end else begin
            state_r     <= state_s;
            wait_cnt_r  <= wait_cnt_s;
            n_r         <= n_s;
            base_r      <= base_s;
            acc_r       <= acc_s;
            mem_rd_en_r <= mem_rd_en_s;
            mem_addr_r  <= mem_addr_s;
            draw_r      <= draw_s;
            x_r         <= x_s;
            y_r         <= y_s;
            row_r       <= row_s;
            data_r      <= data_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            vf_we_r     <= vf_we_s;
            vf_data_r   <= vf_data_s;
        end
    end

    assign mem_rd_en   = mem_rd_en_r;
    assign mem_addr    = mem_addr_r;
    assign draw        = draw_r;
    assign x           = x_r;
    assign y           = y_r;
    assign row_index   = row_r;
    assign sprite_data = data_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign vf_we       = vf_we_r;
    assign vf_data     = vf_data_r;

endmodule

// File: tb/tb_chip8_sprite_fetch.sv
// -----------------------------------------------------------------------------
// tb_chip8_sprite_fetch
//
// Directed and randomized bench for chip8_sprite_fetch in its default build
// (no clipping), with MEM_LAT = 1. The expected behaviour is built from
// plain arithmetic:
//   - row r reads address (I + r) mod 4096;
//   - each draw shows row r and mem[(I + r) mod 4096];
//   - done comes n*(MEM_LAT+3)+1 cycles after acceptance;
//   - VF is the OR of the planned per-row collisions.
// A memory model and a display collision model run alongside the DUT.
// Both drive random junk whenever their outputs are not meant to be valid.
// -----------------------------------------------------------------------------
module tb_chip8_sprite_fetch;

    localparam int AW  = 12;
    localparam int LAT = 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    vx;
    logic [7:0]    vy;
    logic [3:0]    n;
    logic [AW-1:0] i_reg;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          draw;
    logic [5:0]    x;
    logic [4:0]    y;
    logic [3:0]    row_index;
    logic [7:0]    sprite_data;
    logic          collision;
    logic          busy;
    logic          done;
    logic          vf_we;
    logic [7:0]    vf_data;

    logic [7:0]    mem [0:4095];
    logic [14:0]   coll_plan;
    int            n_assert;
    int            n_fail;

    chip8_sprite_fetch #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .vx(vx), .vy(vy), .n(n),
        .i_reg(i_reg), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .draw(draw), .x(x), .y(y),
        .row_index(row_index), .sprite_data(sprite_data),
        .collision(collision), .busy(busy), .done(done), .vf_we(vf_we),
        .vf_data(vf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with a one-cycle read latency. It returns junk when no read is pending.
    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);
    end

    // Display model: the collision flag for the drawn row is registered on the draw edge.
    // Between draws it returns junk.
    always @(posedge clk) begin
        collision <= draw ? coll_plan[row_index] : 1'($urandom);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one DXYN operation and checks every read, draw and the done pulse.
    // b2b: issue start at the current negedge (right after a done).
    // repulse_k >= 0: also pulse start mid-sequence and during FINISH.
    task automatic run_op(input logic [7:0] t_vx, input logic [7:0] t_vy,
                          input logic [3:0] t_n, input logic [11:0] t_i,
                          input logic [14:0] t_coll, input bit b2b,
                          input int repulse_k);
        int          exp_done;
        int          nrd;
        int          ndr;
        bit          got;
        logic        exp_vf;
        logic [11:0] ea;
        coll_plan = t_coll;
        exp_done  = int'(t_n) * (LAT + 3) + 1;
        exp_vf    = 1'b0;
        for (int r = 0; r < int'(t_n); r++) exp_vf = exp_vf | t_coll[r];
        if (!b2b) @(negedge clk);
        vx = t_vx; vy = t_vy; n = t_n; i_reg = t_i; start = 1'b1;
        got = 1'b0; nrd = 0; ndr = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            start = (repulse_k >= 0) && ((k == repulse_k) || (k == exp_done - 1));
            if (start) begin
                n = 4'(($urandom % 15) + 1); i_reg = 12'($urandom);
            end
            if (k == 0) check("busy_after_accept", 64'(busy), 64'd1);
            if (mem_rd_en) begin
                ea = t_i + 12'(nrd);
                check("mem_addr", 64'(mem_addr), 64'(ea));
                nrd++;
            end
            if (draw) begin
                ea = t_i + 12'(ndr);
                check("row_index", 64'(row_index), 64'(ndr));
                check("sprite_data", 64'(sprite_data), 64'(mem[ea]));
                check("x_y", 64'({x, y}), 64'({t_vx[5:0], t_vy[4:0]}));
                ndr++;
            end
            if (done) begin
                got = 1'b1;
                check("done_latency", 64'(k), 64'(exp_done));
                check("vf_we_with_done", 64'(vf_we), 64'd1);
                check("vf_data", 64'(vf_data), 64'({7'd0, exp_vf}));
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
        start = 1'b0;
        check("done_seen", 64'(got), 64'd1);
        check("read_count", 64'(nrd), 64'(t_n));
        check("draw_count", 64'(ndr), 64'(t_n));
        if (repulse_k >= 0) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("idle_after_repulse", 64'({busy, draw, mem_rd_en, done}), 64'd0);
            end
        end
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        reset = 1'b0; start = 1'b0; vx = 8'h00; vy = 8'h00; n = 4'd0;
        i_reg = 12'h000; coll_plan = 15'h0000;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        mem[12'h050] = 8'hF0; mem[12'h051] = 8'h90; mem[12'h052] = 8'h90;
        mem[12'h053] = 8'h90; mem[12'h054] = 8'hF0;

        // Reset state: every output is low while reset is held.
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({mem_rd_en, mem_addr, draw, x, y, row_index, sprite_data,
                                    busy, done, vf_we, vf_data}), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reference sprite: no collision, then a collision on row 2 only.
        run_op(8'h00, 8'h00, 4'd5, 12'h050, 15'h0000, 1'b0, -1);
        run_op(8'h00, 8'h00, 4'd5, 12'h050, 15'h0004, 1'b0, -1);
        // Zero-height sprite, then a start accepted in the cycle right after done.
        run_op(8'h12, 8'h34, 4'd0, 12'h200, 15'h7FFF, 1'b0, -1);
        run_op(8'h45, 8'h23, 4'd3, 12'hFFE, 15'h0000, 1'b1, -1);
        // Fifteen rows that wrap across the top of memory.
        run_op(8'hFF, 8'hFF, 4'd15, 12'hFF8, 15'h4000, 1'b0, -1);
        // start pulses mid-sequence and during FINISH are dropped.
        run_op(8'h07, 8'h09, 4'd4, 12'h300, 15'h0002, 1'b0, 5);

        // Randomized operations.
        for (int it = 0; it < 6; it++) begin
            run_op(8'($urandom), 8'($urandom), 4'($urandom_range(1, 15)), 12'($urandom),
                   (it % 2 == 1) ? 15'($urandom) : 15'h0000, 1'b0, -1);
        end

        // Reset asserted during WAIT aborts at once, and no done follows.
        @(negedge clk);
        vx = 8'h01; vy = 8'h02; n = 4'd3; i_reg = 12'h100; coll_plan = 15'h7FFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_outputs", 64'({mem_rd_en, mem_addr, draw, x, y, row_index, sprite_data,
                                   busy, done, vf_we, vf_data}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("no_done_after_abort", 64'({done, vf_we, draw, busy, mem_rd_en}), 64'd0);
        end
        // A normal operation still works after the abort.
        run_op(8'h3C, 8'h1E, 4'd2, 12'h123, 15'h0001, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
